// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: left-to-right square-and-multiply sequencer driving one montgomery multiplier.
// Define MONT_EXP_CONVERT_EN to append A*1 so the result leaves the Montgomery domain.
module mont_exp_ctrl #(
   parameter int WIDTH     = 1024,
   parameter int EXP_LEN_W = 11
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     in_m,
   input  logic [WIDTH-1:0]     in_x_tilde,
   input  logic [WIDTH-1:0]     in_a_init,
   input  logic [WIDTH-1:0]     in_exp,
   input  logic [EXP_LEN_W-1:0] in_exp_len,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     result,
   output logic                 mont_start,
   output logic [WIDTH-1:0]     mont_in_a,
   output logic [WIDTH-1:0]     mont_in_b,
   output logic [WIDTH-1:0]     mont_in_m,
   input  logic [WIDTH-1:0]     mont_result,
   input  logic                 mont_done
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [EXP_LEN_W-1:0] LEN_MAX = EXP_LEN_W'(WIDTH);

`ifdef MONT_EXP_CONVERT_EN
   localparam bit CONV_EN = 1'b1;
`else
   localparam bit CONV_EN = 1'b0;
`endif

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_SQ_ISSUE,
      S_SQ_WAIT,
      S_MUL_ISSUE,
      S_MUL_WAIT,
      S_NEXT,
      S_CONV_ISSUE,
      S_CONV_WAIT,
      S_FINISH
   } state_t;

   state_t state_q, state_d, tail_st;

   logic [WIDTH-1:0]     a_q, x_q, e_q;
   logic [IDX_W-1:0]     idx_q;
   logic [EXP_LEN_W-1:0] len_sat;
   logic                 len_zero_q;
   logic                 first_q;
   logic                 mont_ok;
   logic                 issue;

   assign len_sat = (in_exp_len > LEN_MAX) ? LEN_MAX : in_exp_len;
   // done is masked in the cycle mont_start is high: it may still be the previous op's level
   assign mont_ok = mont_done & ~first_q;
   assign issue   = state_q inside {S_SQ_ISSUE, S_MUL_ISSUE, S_CONV_ISSUE};
   assign tail_st = CONV_EN ? S_CONV_ISSUE : S_FINISH;
   assign busy    = (state_q != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:       if (start) state_d = S_LOAD;
         S_LOAD:       state_d = len_zero_q ? tail_st : S_SQ_ISSUE;
         S_SQ_ISSUE:   state_d = S_SQ_WAIT;
         S_SQ_WAIT:
            if (mont_ok) state_d = e_q[idx_q] ? S_MUL_ISSUE : S_NEXT;
         S_MUL_ISSUE:  state_d = S_MUL_WAIT;
         S_MUL_WAIT:   if (mont_ok) state_d = S_NEXT;
         S_NEXT:       state_d = (idx_q == '0) ? tail_st : S_SQ_ISSUE;
         S_CONV_ISSUE: state_d = S_CONV_WAIT;
         S_CONV_WAIT:  if (mont_ok) state_d = S_FINISH;
         S_FINISH:     state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q        <= '0;
         x_q        <= '0;
         e_q        <= '0;
         idx_q      <= '0;
         len_zero_q <= 1'b0;
         first_q    <= 1'b0;
         result     <= '0;
         done       <= 1'b0;
         mont_start <= 1'b0;
         mont_in_a  <= '0;
         mont_in_b  <= '0;
         mont_in_m  <= '0;
      end else begin
         mont_start <= issue;
         first_q    <= issue;
         done       <= (state_q == S_FINISH);
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mont_in_m  <= in_m;
                  x_q        <= in_x_tilde;
                  e_q        <= in_exp;
                  a_q        <= in_a_init;
                  idx_q      <= IDX_W'(len_sat - 1'b1);
                  len_zero_q <= (len_sat == '0);
               end
            end
            S_SQ_ISSUE: begin
               mont_in_a <= a_q;
               mont_in_b <= a_q;
            end
            S_MUL_ISSUE: begin
               mont_in_a <= a_q;
               mont_in_b <= x_q;
            end
            S_CONV_ISSUE: begin
               mont_in_a <= a_q;
               mont_in_b <= WIDTH'(1);
            end
            S_SQ_WAIT, S_MUL_WAIT, S_CONV_WAIT: begin
               if (mont_ok) a_q <= mont_result;
            end
            S_NEXT: begin
               if (idx_q != '0) idx_q <= idx_q - 1'b1;
            end
            S_FINISH: result <= a_q;
            default: ;
         endcase
      end
   end

endmodule
